linebuf_port_arbiter: RTL and testbench

- Shares one single-port, 2-cycle-read-latency line-buffer RAM (`ram_inference`, DATA_WIDTH × RAM_DEPTH) between a write requester and a read requester in the SGM aggregation path.
- Drives the RAM `en`/`we`/`addr`/`di` signals.
- Because the RAM output registers only advance while `en`=1, the block tracks reads in flight and keeps `en` high until each read has flushed.
- Returns read data with a valid strobe exactly 2 cycles after the read grant.

---
 rtl/linebuf_pkg.sv | 29 ++
 rtl/linebuf_port_arbiter_if.sv | 42 ++++
 rtl/linebuf_rd_tracker.sv | 47 ++++
 rtl/linebuf_port_arbiter.sv | 98 +++++++++
 tb/tb_linebuf_port_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/linebuf_pkg.sv
// -----------------------------------------------------------------------------
// linebuf_pkg
// Shared constants, the read-tag type and a clog2 helper for the line-buffer
// port arbiter slice.
//   LINEBUF_DATA_WIDTH : width of one line-buffer word (cost vector)
//   LINEBUF_DEPTH      : number of words in the line buffer (one image line)
//   rd_tag_t           : per-read flag travelling alongside the RAM pipeline
//   clog2()            : address width for a given depth
// -----------------------------------------------------------------------------
package linebuf_pkg;

    localparam int LINEBUF_DATA_WIDTH = 256;
    localparam int LINEBUF_DEPTH      = 640;

    typedef struct packed {
        logic valid;
        logic err;
    } rd_tag_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/linebuf_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// linebuf_port_arbiter_if
// Bundles the requester handshakes, the read response and the RAM port of the
// line-buffer arbiter.
//   slave  : the arbiter side (takes requests and ram_do, drives grants,
//            response and the RAM controls)
//   master : the surrounding logic (requesters, response consumer, RAM)
// -----------------------------------------------------------------------------
interface linebuf_port_arbiter_if
    import linebuf_pkg::*;
#(
    parameter int DATA_WIDTH   = LINEBUF_DATA_WIDTH,
    parameter int ADDRESS_BITS = clog2(LINEBUF_DEPTH)
);
    logic                    wr_req;
    logic [ADDRESS_BITS-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    wr_gnt;
    logic                    rd_req;
    logic [ADDRESS_BITS-1:0] rd_addr;
    logic                    rd_gnt;
    logic                    rd_valid;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_err;
    logic                    ram_en;
    logic                    ram_we;
    logic [ADDRESS_BITS-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]   ram_di;
    logic [DATA_WIDTH-1:0]   ram_do;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_do,
        output wr_gnt, rd_gnt, rd_valid, rd_data, rd_err,
               ram_en, ram_we, ram_addr, ram_di
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_do,
        input  wr_gnt, rd_gnt, rd_valid, rd_data, rd_err,
               ram_en, ram_we, ram_addr, ram_di
    );
endinterface

// File: rtl/linebuf_rd_tracker.sv
// -----------------------------------------------------------------------------
// linebuf_rd_tracker
// Two-stage read-tag pipeline that advances in lock-step with the RAM's
// en-gated output registers, so a tag leaves stage 2 exactly when its data is
// on ram_do.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_en         : RAM enable this cycle (pipeline advance)
//   i_load       : a read is granted this cycle
//   i_tag        : tag for the granted read
//   o_p1_valid   : a read sits in stage 1 and still needs one enable
//   o_rd_valid   : stage-2 valid (response strobe)
//   o_rd_err     : stage-2 error flag
// -----------------------------------------------------------------------------
module linebuf_rd_tracker
    import linebuf_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_en,
    input  logic    i_load,
    input  rd_tag_t i_tag,
    output logic    o_p1_valid,
    output logic    o_rd_valid,
    output logic    o_rd_err
);
    rd_tag_t r_p1;
    rd_tag_t r_p2;

    // A load always coincides with i_en (a grant forces en), and a valid p1
    // also forces en, so p1 never needs to hold a live tag across an idle cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1 <= '0;
            r_p2 <= '0;
        end else if (i_en) begin
            r_p1 <= i_load ? i_tag : '0;
            r_p2 <= r_p1;
        end else begin
            r_p2 <= '0;
        end
    end

    assign o_p1_valid = r_p1.valid;
    assign o_rd_valid = r_p2.valid;
    assign o_rd_err   = r_p2.err;
endmodule

// File: rtl/linebuf_port_arbiter.sv
// -----------------------------------------------------------------------------
// linebuf_port_arbiter
// Shares one single-port, 2-cycle-read-latency line-buffer RAM between a write
// requester and a read requester. Grants are combinational; read responses
// come back with rd_valid exactly two cycles after rd_gnt.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : linebuf_port_arbiter_if.slave (requests, grants, response,
//              RAM en/we/addr/di/do)
// Build option:
//   LINEBUF_RD_PRIO_EN defined   -> read always wins a conflict
//   LINEBUF_RD_PRIO_EN undefined -> round-robin, write wins the first conflict
// -----------------------------------------------------------------------------
module linebuf_port_arbiter
    import linebuf_pkg::*;
#(
    parameter int DATA_WIDTH = LINEBUF_DATA_WIDTH,
    parameter int RAM_DEPTH  = LINEBUF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    linebuf_port_arbiter_if.slave   bus
);
    localparam int ADDRESS_BITS = clog2(RAM_DEPTH);
    // One extra bit so a depth that is an exact power of two still compares.
    localparam logic [ADDRESS_BITS:0] ADDR_LIMIT = (ADDRESS_BITS + 1)'(RAM_DEPTH);

    logic                    w_wr_gnt;
    logic                    w_rd_gnt;
    logic [ADDRESS_BITS-1:0] w_addr;
    logic [DATA_WIDTH-1:0]   w_di;
    logic                    w_in_range;
    logic                    w_we;
    logic                    w_en;
    logic                    w_p1_valid;
    logic                    w_rd_valid;
    logic                    w_rd_err;
    rd_tag_t                 w_tag;

    // Grants are masked by rst so the RAM port is quiet while reset is held.
`ifdef LINEBUF_RD_PRIO_EN
    assign w_rd_gnt = !rst && bus.rd_req;
    assign w_wr_gnt = !rst && bus.wr_req && !bus.rd_req;
`else
    logic r_last;   // 0: write served last, 1: read served last

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_wr_gnt) begin
            r_last <= 1'b0;
        end else if (w_rd_gnt) begin
            r_last <= 1'b1;
        end
    end

    assign w_wr_gnt = !rst && bus.wr_req && (!bus.rd_req || r_last);
    assign w_rd_gnt = !rst && bus.rd_req && (!bus.wr_req || !r_last);
`endif

    always_comb begin
        w_addr = '0;
        w_di   = '0;
        if (w_wr_gnt) begin
            w_addr = bus.wr_addr;
            w_di   = bus.wr_data;
        end else if (w_rd_gnt) begin
            w_addr = bus.rd_addr;
        end
    end

    assign w_in_range = ({1'b0, w_addr} < ADDR_LIMIT);
    assign w_we       = w_wr_gnt && w_in_range;
    // p1 keeps en up for the cycle after each read so its data reaches ram_do.
    assign w_en       = w_rd_gnt || w_we || w_p1_valid;
    assign w_tag      = '{valid: 1'b1, err: !w_in_range};

    linebuf_rd_tracker u_rd_tracker (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_en),
        .i_load     (w_rd_gnt),
        .i_tag      (w_tag),
        .o_p1_valid (w_p1_valid),
        .o_rd_valid (w_rd_valid),
        .o_rd_err   (w_rd_err)
    );

    assign bus.wr_gnt   = w_wr_gnt;
    assign bus.rd_gnt   = w_rd_gnt;
    assign bus.ram_en   = w_en;
    assign bus.ram_we   = w_we;
    assign bus.ram_addr = w_addr;
    assign bus.ram_di   = w_di;
    assign bus.rd_valid = w_rd_valid;
    assign bus.rd_err   = w_rd_err;
    assign bus.rd_data  = (w_rd_valid && !w_rd_err) ? bus.ram_do : '0;
endmodule

// File: tb/tb_linebuf_port_arbiter.sv
module tb_linebuf_port_arbiter;
    import linebuf_pkg::*;

    localparam int DW = 256;
    localparam int AB = 10;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    linebuf_port_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB)) bus ();

    linebuf_port_arbiter #(.DATA_WIDTH(DW), .RAM_DEPTH(640)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ram_inference: en-gated, read-first, two output registers.
    logic [DW-1:0] mem [0:1023];
    logic [DW-1:0] r_q1;
    logic [DW-1:0] r_do;

    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_di;
            r_q1 <= mem[bus.ram_addr];
            r_do <= r_q1;
        end
    end
    assign bus.ram_do = r_do;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_req  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_req  = 1'b0;
        bus.rd_addr = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.wr_req = 1'b1; bus.wr_addr = 10'd4; bus.wr_data = DW'(32'h55);
        bus.rd_req = 1'b1; bus.rd_addr = 10'd4;
        tick();
        @(negedge clk);
        n_checks++; if (bus.wr_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_wr_gnt: got %b want 0", bus.wr_gnt); end
        n_checks++; if (bus.rd_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_rd_gnt: got %b want 0", bus.rd_gnt); end
        n_checks++; if (bus.ram_en !== 1'b0) begin n_fail++; $display("FAIL rst_ram_en: got %b want 0", bus.ram_en); end
        n_checks++; if (bus.ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_ram_we: got %b want 0", bus.ram_we); end
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rd_valid: got %b want 0", bus.rd_valid); end
        n_checks++; if (bus.rd_err !== 1'b0) begin n_fail++; $display("FAIL rst_rd_err: got %b want 0", bus.rd_err); end
        n_checks++; if (bus.rd_data !== '0) begin n_fail++; $display("FAIL rst_rd_data: got %h want 0", bus.rd_data); end
        n_checks++; if (bus.ram_addr !== '0 || bus.ram_di !== '0) begin n_fail++; $display("FAIL rst_ram_bus: got addr %h di %h want 0", bus.ram_addr, bus.ram_di); end
        tick();
        idle_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        bus.wr_req = 1'b1; bus.wr_addr = 10'd3; bus.wr_data = DW'(32'hA5);
        @(negedge clk);
        n_checks++; if (bus.wr_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %b want 1", bus.wr_gnt); end
        n_checks++; if (bus.ram_we !== 1'b1 || bus.ram_en !== 1'b1) begin n_fail++; $display("FAIL wr_we_en: got we %b en %b want 1 1", bus.ram_we, bus.ram_en); end
        n_checks++; if (bus.ram_addr !== 10'd3 || bus.ram_di !== DW'(32'hA5)) begin n_fail++; $display("FAIL wr_addr_di: got %h %h want 3 a5", bus.ram_addr, bus.ram_di); end
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++; if (bus.ram_en !== 1'b0) begin n_fail++; $display("FAIL idle_ram_en: got %b want 0", bus.ram_en); end
        tick(); tick();
        bus.rd_req = 1'b1; bus.rd_addr = 10'd3;
        @(negedge clk);
        n_checks++; if (bus.rd_gnt !== 1'b1 || bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0) begin n_fail++; $display("FAIL rd_grant_cycle: got gnt %b en %b we %b want 1 1 0", bus.rd_gnt, bus.ram_en, bus.ram_we); end
        n_checks++; if (bus.ram_addr !== 10'd3) begin n_fail++; $display("FAIL rd_ram_addr: got %h want 3", bus.ram_addr); end
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++; if (bus.ram_en !== 1'b1) begin n_fail++; $display("FAIL rd_flush_en: got %b want 1", bus.ram_en); end
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_t1: got %b want 0", bus.rd_valid); end
        tick();
        @(negedge clk);
        n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_err !== 1'b0) begin n_fail++; $display("FAIL rd_valid_t2: got valid %b err %b want 1 0", bus.rd_valid, bus.rd_err); end
        n_checks++; if (bus.rd_data !== DW'(32'hA5)) begin n_fail++; $display("FAIL rd_data_t2: got %h want a5", bus.rd_data); end
        n_checks++; if (bus.ram_en !== 1'b0) begin n_fail++; $display("FAIL rd_en_after: got %b want 0", bus.ram_en); end
        tick();
        @(negedge clk);
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_t3: got %b want 0", bus.rd_valid); end
        tick();
    endtask

    task automatic test_conflict();
        logic exp_w;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.wr_req = 1'b1; bus.wr_addr = 10'd10; bus.wr_data = DW'(32'h11);
            bus.rd_req = 1'b1; bus.rd_addr = 10'd11;
`ifdef LINEBUF_RD_PRIO_EN
            exp_w = 1'b0;
`else
            exp_w = (i % 2 == 0);
`endif
            @(negedge clk);
            n_checks++; if (bus.wr_gnt !== exp_w || bus.rd_gnt !== !exp_w) begin n_fail++; $display("FAIL conflict_%0d: got wr %b rd %b want wr %b rd %b", i, bus.wr_gnt, bus.rd_gnt, exp_w, !exp_w); end
            tick();
        end
        idle_inputs();
        tick(); tick(); tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            bus.wr_req = 1'b1; bus.wr_addr = AB'(i); bus.wr_data = DW'(i);
            tick();
        end
        idle_inputs();
        tick();
        for (int i = 0; i < 11; i++) begin
            bus.rd_req  = (i < 8);
            bus.rd_addr = (i < 8) ? AB'(i) : '0;
            @(negedge clk);
            if (i >= 2 && i < 10) begin
                n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== DW'(i - 2)) begin n_fail++; $display("FAIL b2b_resp_%0d: got valid %b data %h want 1 %h", i, bus.rd_valid, bus.rd_data, i - 2); end
            end else begin
                n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_%0d: got valid %b want 0", i, bus.rd_valid); end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_out_of_range();
        bus.rd_req = 1'b1; bus.rd_addr = 10'd700;
        @(negedge clk);
        n_checks++; if (bus.rd_gnt !== 1'b1 || bus.ram_en !== 1'b1) begin n_fail++; $display("FAIL oor_rd_gnt: got gnt %b en %b want 1 1", bus.rd_gnt, bus.ram_en); end
        tick();
        idle_inputs();
        tick();
        @(negedge clk);
        n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_err !== 1'b1) begin n_fail++; $display("FAIL oor_rd_resp: got valid %b err %b want 1 1", bus.rd_valid, bus.rd_err); end
        n_checks++; if (bus.rd_data !== '0) begin n_fail++; $display("FAIL oor_rd_data: got %h want 0", bus.rd_data); end
        tick();
        bus.wr_req = 1'b1; bus.wr_addr = 10'd700; bus.wr_data = '1;
        @(negedge clk);
        n_checks++; if (bus.wr_gnt !== 1'b1) begin n_fail++; $display("FAIL oor_wr_gnt: got %b want 1", bus.wr_gnt); end
        n_checks++; if (bus.ram_we !== 1'b0 || bus.ram_en !== 1'b0) begin n_fail++; $display("FAIL oor_wr_we: got we %b en %b want 0 0", bus.ram_we, bus.ram_en); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_ordering();
        bus.wr_req = 1'b1; bus.wr_addr = 10'd5; bus.wr_data = DW'(1);
        tick();
        idle_inputs();
        tick();
        bus.rd_req = 1'b1; bus.rd_addr = 10'd5;
        tick();
        idle_inputs();
        bus.wr_req = 1'b1; bus.wr_addr = 10'd5; bus.wr_data = DW'(9);
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== DW'(1)) begin n_fail++; $display("FAIL order_old: got valid %b data %h want 1 1", bus.rd_valid, bus.rd_data); end
        tick();
        bus.wr_req = 1'b1; bus.wr_addr = 10'd5; bus.wr_data = DW'(7);
        tick();
        idle_inputs();
        bus.rd_req = 1'b1; bus.rd_addr = 10'd5;
        tick();
        idle_inputs();
        tick();
        @(negedge clk);
        n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== DW'(7)) begin n_fail++; $display("FAIL order_new: got valid %b data %h want 1 7", bus.rd_valid, bus.rd_data); end
        tick();
    endtask

    task automatic test_reset_midflight();
        logic exp_w;
`ifdef LINEBUF_RD_PRIO_EN
        exp_w = 1'b0;
`else
        exp_w = 1'b1;
`endif
        bus.rd_req = 1'b1; bus.rd_addr = 10'd3;
        @(negedge clk);
        n_checks++; if (bus.rd_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_rd_gnt: got %b want 1", bus.rd_gnt); end
        tick();
        rst = 1'b1;
        bus.wr_req = 1'b1; bus.wr_addr = 10'd8; bus.wr_data = DW'(32'h33);
        bus.rd_req = 1'b1; bus.rd_addr = 10'd3;
        @(negedge clk);
        n_checks++; if (bus.wr_gnt !== 1'b0 || bus.rd_gnt !== 1'b0 || bus.ram_en !== 1'b0 || bus.ram_we !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ctrl: got wg %b rg %b en %b we %b want 0", bus.wr_gnt, bus.rd_gnt, bus.ram_en, bus.ram_we); end
        n_checks++; if (bus.rd_valid !== 1'b0 || bus.rd_err !== 1'b0 || bus.rd_data !== '0) begin n_fail++; $display("FAIL mid_rst_resp: got valid %b err %b data %h want 0", bus.rd_valid, bus.rd_err, bus.rd_data); end
        tick();
        @(negedge clk);
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_lost_read: got valid %b want 0", bus.rd_valid); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.wr_gnt !== exp_w || bus.rd_gnt !== !exp_w) begin n_fail++; $display("FAIL mid_first_conflict: got wr %b rd %b want wr %b rd %b", bus.wr_gnt, bus.rd_gnt, exp_w, !exp_w); end
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_release_valid: got %b want 0", bus.rd_valid); end
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after_valid: got %b want 0", bus.rd_valid); end
        tick(); tick(); tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_write_read();
        test_conflict();
        test_back_to_back();
        test_out_of_range();
        test_ordering();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
